exec_div_unit: RTL and testbench
================================

// Module: exec_div_unit
// PURPOSE
// - Iterative 32-bit divide/remainder unit (RV32M DIV/DIVU/REM/REMU) directly downstream of the execution reservation station.
// - Accepts one ready entry (both operands valid) per operation, runs a radix-2 restoring divide, then broadcasts the result on the CDB.
// - Only one operation is in flight; o_busy back-pressures the reservation-station read enable.
// PARAMETERS
// - DATA_WIDTH  128  issued entry width; field map fixed in exec_pkg
// - XLEN        32   operand/result width
// - TAG_W       6    ROB/CDB tag width
// PORTS
// - i_clk         in   1           clock, all logic on rising edge
// - i_rst         in   1           reset, synchronous, active-high
// - i_flush       in   1           pipeline flush, synchronous, abandons in-flight op
// - i_issue_data  in   DATA_WIDTH  entry: [5:0] rd tag, [44:13] rs2 data, [83:52] rs1 data, [86:84] funct3
// - i_issue_valid in   1           entry presented this cycle
// - o_busy        out  1           unit occupied; station must not issue while high
// - o_cdb_req     out  1           result ready, requesting CDB
// - i_cdb_gnt     in   1           CDB arbiter grant
// - o_cdb_valid   out  1           result driven on CDB this cycle
// - o_cdb_tag     out  TAG_W       destination tag
// - o_cdb_data    out  XLEN        quotient or remainder
// BEHAVIOUR
// - One clock, synchronous active-high reset; reset and flush identical: state IDLE, all outputs 0.
// - States: IDLE -> DIV -> FIX -> WB -> IDLE.
// - IDLE: o_busy=0. i_issue_valid latches rs1, rs2, tag, funct3; takes |rs1|,|rs2| for signed ops (funct3[0]=0); records quotient/remainder sign; count=0; -> DIV.
// - DIV: one restoring step per cycle (rem = {rem,dividend msb} - divisor, keep if non-negative, shift quotient bit); 32 cycles, count 0..31; -> FIX when count==31.
// - FIX: negate quotient if signs of rs1/rs2 differ; remainder takes sign of rs1; select quotient (funct3[1]=0) or remainder; -> WB.
// - WB: o_cdb_req=1, holds tag/data stable until i_cdb_gnt; on grant o_cdb_valid=1 for exactly that cycle, -> IDLE.
// - o_busy=1 in DIV, FIX, WB; an issue arriving while busy is ignored (station protocol violation, assertion).
// - Latency, issue to first o_cdb_req: 34 cycles (1 latch + 32 DIV + 1 FIX).
// - Divide by zero: quotient 0xFFFFFFFF, remainder = rs1 (signed and unsigned).
// - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
// - Special results are fixed in FIX, overriding the datapath; -(2^31) magnitude handled as unsigned 33-bit.
// - Flush or reset in any state, including WB with grant in the same cycle: flush wins, no o_cdb_valid.
// - i_cdb_gnt outside WB is ignored.
// CONFIGURATION
// - EXEC_DIV_EARLY_OUT_EN defined: divide-by-zero, signed overflow and |rs2|==1 skip DIV; IDLE -> FIX -> WB, o_cdb_req 2 cycles after issue.
// - Not defined: every operation takes fixed 34-cycle latency; special cases resolved in FIX only.
// STRUCTURE
// - exec_pkg: entry field bit positions, funct3 encodings (DIV=3'b100, DIVU=3'b101, REM=3'b110, REMU=3'b111), div_state_t enum, TAG_W/XLEN constants.
// - Sub-module exec_div_step: combinational single restoring iteration (rem_in, quo_in, divisor -> rem_out, quo_out); instantiated once.
// TESTING
// - DIVU 100/7, grant held high -> o_cdb_req at cycle 34 after issue, o_cdb_valid with data 14 and issued tag.
// - REM -7/2 and DIV -7/2 -> 0xFFFFFFFF (-1) and 0xFFFFFFFD (-3).
// - DIV x/0, x=0x1234 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234; early-out build: req 2 cycles after issue.
// - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
// - Grant withheld 5 cycles in WB -> req, tag, data stable; o_busy high; single-cycle o_cdb_valid on grant.
// - Flush at DIV cycle 10 and at WB with simultaneous grant -> IDLE next cycle, no o_cdb_valid, next issue accepted.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execution divide unit: widths, issue-entry field
// map, RV32M divide funct3 encodings, FSM state type and small helpers.
package exec_pkg;

   localparam int unsigned DATA_WIDTH = 128;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned TAG_W      = 6;
   localparam int unsigned CNT_W      = 5;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   // Issued reservation-station entry, MSB first.
   typedef struct packed {
      logic [40:0]      rsvd_hi;   // [127:87]
      logic [2:0]       funct3;    // [86:84]
      logic [XLEN-1:0]  rs1;       // [83:52]
      logic [6:0]       rsvd_mid;  // [51:45]
      logic [XLEN-1:0]  rs2;       // [44:13]
      logic [6:0]       rsvd_lo;   // [12:6]
      logic [TAG_W-1:0] tag;       // [5:0]
   } issue_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_FIX  = 2'd2,
      ST_WB   = 2'd3
   } div_state_t;

   // Signed DIV/REM treat operands as two's complement.
   function automatic logic f3_is_signed(input logic [2:0] f3);
      return (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   // REM/REMU return the remainder, DIV/DIVU the quotient.
   function automatic logic f3_is_rem(input logic [2:0] f3);
      return !((f3 == F3_DIV) || (f3 == F3_DIVU));
   endfunction

   // Magnitude as unsigned; -(2^31) maps to 0x80000000 which is exact unsigned.
   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[XLEN-1]) ? XLEN'(-v) : v;
   endfunction

endpackage

// File: rtl/exec_div_step.sv
// One radix-2 restoring divide iteration: shift the dividend MSB into the
// partial remainder, trial-subtract the divisor, keep on non-negative.
module exec_div_step
   import exec_pkg::*;
(
   input  logic [XLEN-1:0] i_rem_in,
   input  logic [XLEN-1:0] i_quo_in,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_rem_out_c,
   output logic [XLEN-1:0] o_quo_out_c
);

   logic [XLEN+1:0] w_trial;
   logic            w_unused_trial;

   // Partial remainder stays below the divisor, so a kept difference fits XLEN bits.
   always_comb begin
      w_trial     = {1'b0, i_rem_in, i_quo_in[XLEN-1]} - {2'b00, i_divisor};
      o_rem_out_c = {i_rem_in[XLEN-2:0], i_quo_in[XLEN-1]};
      o_quo_out_c = {i_quo_in[XLEN-2:0], 1'b0};
      if (!w_trial[XLEN+1]) begin
         o_rem_out_c = w_trial[XLEN-1:0];
         o_quo_out_c = {i_quo_in[XLEN-2:0], 1'b1};
      end
   end

   assign w_unused_trial = w_trial[XLEN];

endmodule

// File: rtl/exec_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit behind the execution reservation
// station; one op in flight, result broadcast on the CDB after arbitration.
// Optional build macro EXEC_DIV_EARLY_OUT_EN: divide-by-zero, signed overflow
// and unit divisors bypass the iteration (IDLE -> FIX -> WB).
module exec_div_unit
   import exec_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_flush,
   input  logic [DATA_WIDTH-1:0] i_issue_data,
   input  logic                  i_issue_valid,
   output logic                  o_busy,
   output logic                  o_cdb_req,
   input  logic                  i_cdb_gnt,
   output logic                  o_cdb_valid,
   output logic [TAG_W-1:0]      o_cdb_tag,
   output logic [XLEN-1:0]       o_cdb_data
);

   issue_entry_t     w_entry;
   logic             w_sgn;
   logic [XLEN-1:0]  w_rs1_mag;
   logic [XLEN-1:0]  w_rs2_mag;
   logic             w_div0;
   logic             w_ovf;
   logic             w_early;
   logic             w_unused_rsvd;

   div_state_t       r_state;
   div_state_t       w_state_nxt;
   logic             w_cdb_valid;

   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0]  r_rem;
   logic [XLEN-1:0]  r_quo;
   logic [XLEN-1:0]  r_dvs;
   logic [XLEN-1:0]  r_rs1;
   logic [TAG_W-1:0] r_tag;
   logic             r_is_rem;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_div0;
   logic             r_ovf;

   logic [XLEN-1:0]  w_step_rem;
   logic [XLEN-1:0]  w_step_quo;
   logic [XLEN-1:0]  w_quo_fix;
   logic [XLEN-1:0]  w_rem_fix;
   logic [XLEN-1:0]  w_result;

   logic             r_busy;
   logic             r_cdb_req;
   logic [TAG_W-1:0] r_cdb_tag;
   logic [XLEN-1:0]  r_cdb_data;

   // Decode the presented entry and classify special operand combinations.
   assign w_entry       = i_issue_data;
   assign w_sgn         = f3_is_signed(w_entry.funct3);
   assign w_rs1_mag     = mag(w_entry.rs1, w_sgn);
   assign w_rs2_mag     = mag(w_entry.rs2, w_sgn);
   assign w_div0        = (w_entry.rs2 == '0);
   assign w_ovf         = w_sgn && (w_entry.rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                          (w_entry.rs2 == '1);
   assign w_unused_rsvd = ^{w_entry.rsvd_hi, w_entry.rsvd_mid, w_entry.rsvd_lo};

`ifdef EXEC_DIV_EARLY_OUT_EN
   // Unit divisor: quotient is the dividend magnitude already loaded, remainder 0.
   assign w_early = w_div0 || w_ovf || (w_rs2_mag == XLEN'(1));
`else
   assign w_early = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state and the same-cycle CDB valid strobe; flush/reset override everything.
   always_comb begin
      w_state_nxt = r_state;
      w_cdb_valid = 1'b0;
      unique case (r_state)
         ST_IDLE: if (i_issue_valid) w_state_nxt = w_early ? ST_FIX : ST_DIV;
         ST_DIV:  if (r_cnt == CNT_W'(XLEN-1)) w_state_nxt = ST_FIX;
         ST_FIX:  w_state_nxt = ST_WB;
         ST_WB: begin
            if (i_cdb_gnt) begin
               w_state_nxt = ST_IDLE;
               w_cdb_valid = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (i_flush || i_rst) begin
         w_state_nxt = ST_IDLE;
         w_cdb_valid = 1'b0;
      end
   end

   exec_div_step u_step (
      .i_rem_in    (r_rem),
      .i_quo_in    (r_quo),
      .i_divisor   (r_dvs),
      .o_rem_out_c (w_step_rem),
      .o_quo_out_c (w_step_quo)
   );

   // Operand capture on accept, then one restoring step per DIV cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_rs1    <= '0;
         r_tag    <= '0;
         r_is_rem <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_ovf    <= 1'b0;
      end else if ((r_state == ST_IDLE) && i_issue_valid) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= w_rs1_mag;
         r_dvs    <= w_rs2_mag;
         r_rs1    <= w_entry.rs1;
         r_tag    <= w_entry.tag;
         r_is_rem <= f3_is_rem(w_entry.funct3);
         r_neg_q  <= w_sgn && (w_entry.rs1[XLEN-1] ^ w_entry.rs2[XLEN-1]);
         r_neg_r  <= w_sgn && w_entry.rs1[XLEN-1];
         r_div0   <= w_div0;
         r_ovf    <= w_ovf;
      end else if (r_state == ST_DIV) begin
         r_rem    <= w_step_rem;
         r_quo    <= w_step_quo;
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end

   // Sign correction and special-case override of the unsigned datapath result.
   always_comb begin
      w_quo_fix = r_neg_q ? XLEN'(-r_quo) : r_quo;
      w_rem_fix = r_neg_r ? XLEN'(-r_rem) : r_rem;
      if (r_div0) begin
         w_quo_fix = '1;
         w_rem_fix = r_rs1;
      end else if (r_ovf) begin
         w_quo_fix = {1'b1, {(XLEN-1){1'b0}}};
         w_rem_fix = '0;
      end
      w_result = r_is_rem ? w_rem_fix : w_quo_fix;
   end

   // Registered status and CDB payload; payload is held through WB and cleared in IDLE.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy     <= 1'b0;
         r_cdb_req  <= 1'b0;
         r_cdb_tag  <= '0;
         r_cdb_data <= '0;
      end else begin
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_cdb_req <= (w_state_nxt == ST_WB);
         if (w_state_nxt == ST_IDLE) begin
            r_cdb_tag  <= '0;
            r_cdb_data <= '0;
         end else if (r_state == ST_FIX) begin
            r_cdb_tag  <= r_tag;
            r_cdb_data <= w_result;
         end
      end
   end

   assign o_busy      = r_busy;
   assign o_cdb_req   = r_cdb_req;
   assign o_cdb_valid = w_cdb_valid;
   assign o_cdb_tag   = r_cdb_tag;
   assign o_cdb_data  = r_cdb_data;

   // The station must hold off while the unit is occupied.
   a_no_issue_while_busy: assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_issue_valid && r_busy));

endmodule

// File: tb/tb_exec_div_unit.sv
// Scoreboard bench for exec_div_unit: driver issues ops and pushes the
// reference result; a negedge monitor pops and compares on every o_cdb_valid.
module tb_exec_div_unit;
   import exec_pkg::*;

   logic                  i_clk = 1'b0;
   logic                  i_rst;
   logic                  i_flush;
   logic [DATA_WIDTH-1:0] i_issue_data;
   logic                  i_issue_valid;
   logic                  o_busy;
   logic                  o_cdb_req;
   logic                  i_cdb_gnt;
   logic                  o_cdb_valid;
   logic [TAG_W-1:0]      o_cdb_tag;
   logic [XLEN-1:0]       o_cdb_data;

   int n_tests = 0;
   int n_fail  = 0;
   int n_valid = 0;
   logic [37:0] exp_q[$];

   always #5 i_clk = ~i_clk;

   exec_div_unit dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_flush       (i_flush),
      .i_issue_data  (i_issue_data),
      .i_issue_valid (i_issue_valid),
      .o_busy        (o_busy),
      .o_cdb_req     (o_cdb_req),
      .i_cdb_gnt     (i_cdb_gnt),
      .o_cdb_valid   (o_cdb_valid),
      .o_cdb_tag     (o_cdb_tag),
      .o_cdb_data    (o_cdb_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
      end
   endtask

   // RV32M semantics from plain integer arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      case (f3)
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      bit sgn;
      bit special;
      sgn     = (f3 == 3'b100) || (f3 == 3'b110);
      special = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
                (b == 1) || (sgn && b == 32'hFFFF_FFFF);
`ifdef EXEC_DIV_EARLY_OUT_EN
      return special ? 2 : 34;
`else
      return (special && 1'b0) ? 2 : 34;
`endif
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] tag);
      i_issue_data          = '0;
      i_issue_data[5:0]     = tag;
      i_issue_data[44:13]   = b;
      i_issue_data[83:52]   = a;
      i_issue_data[86:84]   = f3;
      i_issue_valid         = 1'b1;
   endtask

   // Monitor: every CDB broadcast must match the oldest outstanding expectation.
   always @(negedge i_clk) begin
      if (o_cdb_valid) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL cdb_unexpected tag=%h data=%h @%0t", o_cdb_tag, o_cdb_data, $time);
         end else begin
            logic [37:0] e;
            e = exp_q.pop_front();
            check("cdb_tag", 32'(o_cdb_tag), 32'(e[37:32]));
            check("cdb_data", o_cdb_data, e[31:0]);
         end
      end
   end

   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag, input int gnt_delay, input bit gnt_early);
      logic [31:0] exp_d;
      int          cyc;
      int          nv;
      exp_d = ref_result(f3, a, b);
      exp_q.push_back({tag, exp_d});
      nv = n_valid;
      present(f3, a, b, tag);
      i_cdb_gnt = gnt_early;
      tick();
      i_issue_valid = 1'b0;
      cyc = 1;
      check("busy_after_issue", 32'(o_busy), 32'd1);
      while (!o_cdb_req && cyc < 200) begin
         tick();
         cyc++;
      end
      check("req_latency", 32'(cyc), 32'(ref_latency(f3, a, b)));
      check("req_tag", 32'(o_cdb_tag), 32'(tag));
      check("req_data", o_cdb_data, exp_d);
      if (!gnt_early) begin
         for (int k = 0; k < gnt_delay; k++) begin
            check("hold_req", 32'(o_cdb_req), 32'd1);
            check("hold_busy", 32'(o_busy), 32'd1);
            check("hold_tag", 32'(o_cdb_tag), 32'(tag));
            check("hold_data", o_cdb_data, exp_d);
            tick();
         end
         i_cdb_gnt = 1'b1;
      end
      tick();
      i_cdb_gnt = 1'b0;
      check("valid_pulses", 32'(n_valid - nv), 32'd1);
      check("req_after_gnt", 32'(o_cdb_req), 32'd0);
      check("busy_after_gnt", 32'(o_busy), 32'd0);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 9))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(1, 20));
         5:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog_timeout @%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nv;
      int cyc;
      i_rst = 1'b1; i_flush = 1'b0; i_issue_valid = 1'b0; i_cdb_gnt = 1'b0;
      i_issue_data = '0;
      repeat (3) tick();
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_req", 32'(o_cdb_req), 32'd0);
      check("rst_valid", 32'(o_cdb_valid), 32'd0);
      check("rst_tag", 32'(o_cdb_tag), 32'd0);
      check("rst_data", o_cdb_data, 32'd0);
      i_rst = 1'b0;
      tick();

      run_op(3'b101, 32'd100, 32'd7, 6'd5, 0, 1'b1);
      run_op(3'b110, -32'd7, 32'd2, 6'd6, 1, 1'b0);
      run_op(3'b100, -32'd7, 32'd2, 6'd7, 0, 1'b0);
      run_op(3'b100, 32'h1234, 32'h0, 6'd8, 0, 1'b0);
      run_op(3'b111, 32'h1234, 32'h0, 6'd9, 2, 1'b0);
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 6'd10, 0, 1'b0);
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 6'd11, 0, 1'b0);
      run_op(3'b101, 32'hDEAD_BEEF, 32'd1, 6'd12, 1, 1'b0);
      run_op(3'b100, 32'd12345, 32'd77, 6'd13, 5, 1'b0);

      // Flush while iterating: op abandoned, nothing broadcast.
      nv = n_valid;
      present(3'b100, 32'd1000, 32'd3, 6'd20);
      tick();
      i_issue_valid = 1'b0;
      repeat (10) tick();
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      check("flush_div_busy", 32'(o_busy), 32'd0);
      check("flush_div_req", 32'(o_cdb_req), 32'd0);
      repeat (40) tick();
      check("flush_div_no_valid", 32'(n_valid - nv), 32'd0);
      run_op(3'b111, 32'd1000, 32'd3, 6'd21, 0, 1'b0);

      // Flush in WB coinciding with grant: flush wins.
      nv = n_valid;
      present(3'b101, 32'd500, 32'd9, 6'd22);
      tick();
      i_issue_valid = 1'b0;
      cyc = 1;
      while (!o_cdb_req && cyc < 200) begin
         tick();
         cyc++;
      end
      check("flush_wb_reached", 32'(o_cdb_req), 32'd1);
      i_cdb_gnt = 1'b1;
      i_flush   = 1'b1;
      tick();
      i_cdb_gnt = 1'b0;
      i_flush   = 1'b0;
      check("flush_wb_busy", 32'(o_busy), 32'd0);
      check("flush_wb_req", 32'(o_cdb_req), 32'd0);
      check("flush_wb_data", o_cdb_data, 32'd0);
      check("flush_wb_no_valid", 32'(n_valid - nv), 32'd0);
      run_op(3'b110, 32'd500, -32'd9, 6'd23, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_op(3'(4 + $urandom_range(0, 3)), rand_operand(), rand_operand(),
                6'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0));
      end

      repeat (3) tick();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
